// File: rtl/counter_arb.sv
// -----------------------------------------------------------------------------
// counter_arb
//
// Round-robin arbiter that lends one shared, externally implemented,
// free-running counter to N requesters, one timed interval at a time.
// The winner's interval length is captured at grant time. The counter is then
// cleared through cnt_load/cnt_data, and the block waits until the counter
// reaches the captured length. After that it pulses done for the owner and
// moves the round-robin pointer past it.
//
// State sequence: IDLE -> LOAD -> RUN (L+1 cycles) -> DONE -> IDLE.
// If the owner drops its request during LOAD or RUN, the interval is abandoned
// silently and the block returns to IDLE.
//
// Parameters
//   WIDTH     width of the shared counter and of each interval length
//   N         number of requesters (N >= 2)
//
// Ports
//   clk       single clock, all state changes on the rising edge
//   rst       synchronous, active-high reset
//   req       [N]        req[i] high = requester i wants one interval
//   len       [N*WIDTH]  len[i*WIDTH +: WIDTH] = interval length of requester i
//   gnt       [N]        one-hot owner of the counter (LOAD/RUN/DONE), else 0
//   done      [N]        one-cycle completion pulse for the owner
//   busy                 high whenever the FSM is not in IDLE
//   cnt_load             load strobe to the shared counter (LOAD only)
//   cnt_data  [WIDTH]    load value to the shared counter (always zero)
//   cnt_count [WIDTH]    current value of the shared counter
// -----------------------------------------------------------------------------
module counter_arb #(
    parameter int WIDTH = 5,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] len,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic               busy,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_data,
    input  logic [WIDTH-1:0]   cnt_count
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;      // last requester served (or abandoned)
    logic [PTR_W-1:0]   owner;    // requester holding the counter
    logic [WIDTH-1:0]   span;     // interval length captured at grant

    // Round-robin search results
    logic               found;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   cand;
    int                 idx;

    function automatic logic [N-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Search starts just after the last served requester and wraps, so the
    // most recent owner always has the lowest priority in the next round.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise an unassigned path would infer a latch.
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx  = (int'(ptr) + k) % N;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // The counter value is compared only against the captured span. Changes
    // on len after the grant therefore cannot stretch or shorten an interval.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            ptr      <= PTR_W'(N - 1);   // requester 0 is searched first
            owner    <= '0;
            span     <= '0;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            cnt_load <= 1'b0;
            cnt_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= '0;
                    cnt_load <= 1'b0;
                    cnt_data <= '0;
                    if (found) begin
                        owner    <= pick;
                        span     <= len[int'(pick)*WIDTH +: WIDTH];
                        gnt      <= onehot(pick);
                        busy     <= 1'b1;
                        cnt_load <= 1'b1;        // clear counter during LOAD
                        state    <= LOAD;
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                LOAD: begin
                    cnt_load <= 1'b0;
                    if (!req[owner]) begin
                        // Owner withdrew: abandon and rotate past it.
                        ptr   <= owner;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (!req[owner]) begin
                        // Withdrawal takes priority over a match in the same
                        // cycle; an abandoned interval never reports done.
                        ptr   <= owner;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_count == span) begin
                        done  <= onehot(owner);
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end

                DONE: begin
                    // Forced pass through IDLE before the next grant.
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= owner;
                    state <= IDLE;
                end

                default: begin
                    done     <= '0;
                    gnt      <= '0;
                    busy     <= 1'b0;
                    cnt_load <= 1'b0;
                    cnt_data <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arb.sv
// -----------------------------------------------------------------------------
// tb_counter_arb
//
// Directed testbench for counter_arb with WIDTH=5 and N=4. The bench models
// the shared free-running counter itself. Inputs are driven on the falling
// edge, and outputs are checked on the falling edge that follows, so that the
// FSM state of the cycle is already visible.
// -----------------------------------------------------------------------------
module tb_counter_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [19:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        cnt_load;
    logic [4:0]  cnt_data;
    logic [4:0]  cnt_count = '0;

    int total = 0;
    int bad   = 0;

    counter_arb #(.WIDTH(5), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt_load  (cnt_load),
        .cnt_data  (cnt_data),
        .cnt_count (cnt_count)
    );

    always #5 clk = ~clk;

    // Shared counter model: loads on cnt_load, otherwise +1 per clock.
    always @(posedge clk) begin
        if (cnt_load) cnt_count <= cnt_data;
        else          cnt_count <= cnt_count + 5'd1;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        len = '0;
        tick();
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=%b", gnt, 4'b0000); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b want=%b", done, 4'b0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=%b", busy, 1'b0); end
        total++; if (cnt_load !== 1'b0) begin bad++; $display("FAIL reset_cnt_load got=%b want=%b", cnt_load, 1'b0); end
        total++; if (cnt_data !== 5'd0) begin bad++; $display("FAIL reset_cnt_data got=%0d want=%0d", cnt_data, 0); end
        rst = 1'b0;
        tick();
    endtask

    // req=0001, len0=3 : LOAD at t+1, RUN t+2..t+5, done at t+6, idle at t+7
    task automatic test_single;
        len[0 +: 5] = 5'd3;
        req = 4'b0001;
        tick();                                       // t+1
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=%b", gnt, 4'b0001); end
        total++; if (cnt_load !== 1'b1) begin bad++; $display("FAIL single_load got=%b want=%b", cnt_load, 1'b1); end
        total++; if (cnt_data !== 5'd0) begin bad++; $display("FAIL single_data got=%0d want=%0d", cnt_data, 0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=%b", busy, 1'b1); end
        for (int c = 2; c <= 5; c++) begin
            tick();
            total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_run_done c=%0d got=%b want=%b", c, done, 4'b0000); end
            total++; if (cnt_load !== 1'b0) begin bad++; $display("FAIL single_run_load c=%0d got=%b want=%b", c, cnt_load, 1'b0); end
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_run_gnt c=%0d got=%b want=%b", c, gnt, 4'b0001); end
        end
        tick();                                       // t+6
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b want=%b", done, 4'b0001); end
        req = '0;
        tick();                                       // t+7
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=%b", busy, 1'b0); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_idle_done got=%b want=%b", done, 4'b0000); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_idle_gnt got=%b want=%b", gnt, 4'b0000); end
    endtask

    // req=0100, len2=0 : LOAD t+1, single RUN t+2, done t+3
    task automatic test_zero_len;
        len[10 +: 5] = 5'd0;
        req = 4'b0100;
        tick();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL zero_gnt got=%b want=%b", gnt, 4'b0100); end
        total++; if (cnt_load !== 1'b1) begin bad++; $display("FAIL zero_load got=%b want=%b", cnt_load, 1'b1); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL zero_run_done got=%b want=%b", done, 4'b0000); end
        total++; if (cnt_load !== 1'b0) begin bad++; $display("FAIL zero_run_load got=%b want=%b", cnt_load, 1'b0); end
        tick();
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL zero_done got=%b want=%b", done, 4'b0100); end
        req = '0;
        tick();
    endtask

    // req=1111, all len=1, from reset: done 0001,0010,0100,1000,0001 every 5
    // cycles, with an IDLE cycle (busy low) between consecutive intervals.
    task automatic test_fairness;
        logic [3:0] exp_done;
        logic [3:0] exp_gnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        len = {5'd1, 5'd1, 5'd1, 5'd1};
        req = 4'b1111;
        for (int c = 1; c <= 24; c++) begin
            tick();
            exp_done = '0;
            if (c % 5 == 4) exp_done[(c / 5) % 4] = 1'b1;
            total++; if (done !== exp_done) begin bad++; $display("FAIL fair_done c=%0d got=%b want=%b", c, done, exp_done); end
            if (c % 5 == 1) begin
                exp_gnt = '0;
                exp_gnt[(c / 5) % 4] = 1'b1;
                total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL fair_gnt c=%0d got=%b want=%b", c, gnt, exp_gnt); end
            end
            if (c % 5 == 0) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_idle_gap c=%0d got=%b want=%b", c, busy, 1'b0); end
            end
        end
        req = '0;
        tick();
    endtask

    // req=0010, len1=10, req dropped in the 4th RUN cycle -> idle, no done;
    // then req=0011 goes to requester 0, which then aborts from LOAD.
    task automatic test_abort;
        len[5 +: 5] = 5'd10;
        req = 4'b0010;
        tick();                                       // t+1 LOAD
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL abort_gnt got=%b want=%b", gnt, 4'b0010); end
        tick(); tick(); tick(); tick();               // t+5 = RUN cycle 4
        req = 4'b0000;
        tick();                                       // t+6
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=%b", busy, 1'b0); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL abort_gnt_clr got=%b want=%b", gnt, 4'b0000); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL abort_done got=%b want=%b", done, 4'b0000); end
        req = 4'b0011;
        tick();                                       // t+7 LOAD
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL abort_next_gnt got=%b want=%b", gnt, 4'b0001); end
        req = 4'b0000;                                // withdraw during LOAD
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_load_busy got=%b want=%b", busy, 1'b0); end
        total++; if (cnt_load !== 1'b0) begin bad++; $display("FAIL abort_load_cnt got=%b want=%b", cnt_load, 1'b0); end
        for (int c = 0; c < 12; c++) begin
            tick();
            total++; if (done !== 4'b0000) begin bad++; $display("FAIL abort_late_done c=%0d got=%b want=%b", c, done, 4'b0000); end
        end
    endtask

    // Reset mid-RUN clears everything; afterwards req=1000 wins straight away.
    task automatic test_reset_mid_run;
        len[10 +: 5] = 5'd10;
        req = 4'b0100;
        tick(); tick(); tick();                       // LOAD, RUN, RUN
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL midrst_pre_gnt got=%b want=%b", gnt, 4'b0100); end
        rst = 1'b1;
        req = 4'b0000;
        tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL midrst_gnt got=%b want=%b", gnt, 4'b0000); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=%b", busy, 1'b0); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL midrst_done got=%b want=%b", done, 4'b0000); end
        rst = 1'b0;
        len[15 +: 5] = 5'd0;
        req = 4'b1000;
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL midrst_regnt got=%b want=%b", gnt, 4'b1000); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL midrst_run_done got=%b want=%b", done, 4'b0000); end
        tick();
        total++; if (done !== 4'b1000) begin bad++; $display("FAIL midrst_done3 got=%b want=%b", done, 4'b1000); end
        req = '0;
        tick();
    endtask

    // len0=31: 32 RUN cycles, done at t+34; len is changed to 0 during RUN.
    task automatic test_max_len;
        len[0 +: 5] = 5'd31;
        req = 4'b0001;
        tick();                                       // t+1 LOAD
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL max_gnt got=%b want=%b", gnt, 4'b0001); end
        len[0 +: 5] = 5'd0;
        for (int c = 2; c <= 33; c++) begin
            tick();
            total++; if (done !== 4'b0000) begin bad++; $display("FAIL max_run_done c=%0d got=%b want=%b", c, done, 4'b0000); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL max_run_busy c=%0d got=%b want=%b", c, busy, 1'b1); end
        end
        tick();                                       // t+34
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL max_done got=%b want=%b", done, 4'b0001); end
        req = '0;
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL max_done_pulse got=%b want=%b", done, 4'b0000); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
        test_reset();
        test_single();
        test_zero_len();
        test_fairness();
        test_abort();
        test_reset_mid_run();
        test_max_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_arb.md
COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the width of the shared counter and of each interval length.
REQ-002 The block SHALL have parameter N, default 4, giving the number of requesters (N >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, N bits: req[i] high = requester i wants one timed interval.
REQ-006 The block SHALL have port len, input, N*WIDTH bits: len[i*WIDTH +: WIDTH] = interval length of requester i, sampled at grant.
REQ-007 The block SHALL have port gnt, output, N bits: one-hot owner of the shared counter, or all-zero.
REQ-008 The block SHALL have port done, output, N bits: one-cycle pulse on done[i] when requester i's interval completes.
REQ-009 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 The block SHALL have port cnt_load, output, 1 bit: drives the shared counter's load input.
REQ-011 The block SHALL have port cnt_data, output, WIDTH bits: drives the shared counter's data input.
REQ-012 The block SHALL have port cnt_count, input, WIDTH bits: current value of the shared counter (free-running +1 per clk unless loaded).

Function
REQ-013 The block SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE: if req != 0, the block SHALL select winner w by round-robin, searching from ptr+1 mod N upward; latch w and len of w; go to LOAD. If req == 0, stay in IDLE.
REQ-015 LOAD: the block SHALL assert cnt_load=1 with cnt_data=0 for exactly one cycle, then go to RUN.
REQ-016 RUN: the block SHALL compare cnt_count to the latched length; on equality, go to DONE; otherwise stay.
REQ-017 DONE: the block SHALL pulse done[w]=1 for one cycle, set ptr=w, and go to IDLE.
REQ-018 gnt[w] SHALL be 1 in LOAD, RUN and DONE; gnt SHALL be 0 in IDLE.
REQ-019 Timing SHALL be as follows: req sampled in IDLE at cycle t; LOAD at t+1; RUN at t+2 .. t+2+L; done pulse at t+3+L, where L = latched length.
REQ-020 len = 0 SHALL give one RUN cycle (count 0 matches immediately); len = 2^WIDTH-1 SHALL give 2^WIDTH RUN cycles with no wrap-around past the match.
REQ-021 cnt_load SHALL be 0 and cnt_data SHALL be 0 in every state except LOAD.
REQ-022 Changes to len[w] after the grant SHALL NOT affect the running interval.
REQ-023 If req[w] drops during LOAD or RUN, the block SHALL abort: go to IDLE next cycle, give no done pulse, and set ptr=w.
REQ-024 Requests from non-owners SHALL be ignored until IDLE; there SHALL be no preemption.
REQ-025 When multiple req bits are set in IDLE, exactly one SHALL be granted; after consecutive DONEs with all requests asserted, grants SHALL cycle 0,1,..,N-1,0 (fair).
REQ-026 After DONE the block SHALL pass through one IDLE cycle before the next grant, even with pending requests.

Reset
REQ-027 On rst=1 at posedge clk, the block SHALL go to IDLE with ptr=N-1, so that requester 0 has highest priority first.
REQ-028 During reset, the block SHALL drive gnt=0, done=0, busy=0, cnt_load=0, cnt_data=0.
REQ-029 Reset asserted in any state, including mid-RUN, SHALL override all other behaviour; no done pulse SHALL be issued for an interrupted interval.

Verification
REQ-030 Single request: req=0001, len0=3 at cycle t -> gnt=0001 from t+1, cnt_load=1 at t+1, done=0001 only at t+6, busy low at t+7.
REQ-031 Zero length: req=0100, len2=0 -> LOAD at t+1, RUN at t+2, done=0100 at t+3.
REQ-032 Fairness: req=1111 held, all len=1 -> done pulses in order 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart.
REQ-033 Abort: req=0010, len1=10, req[1] dropped at RUN cycle 4 -> IDLE next cycle, no done, next grant with req=0011 goes to requester 0.
REQ-034 Reset mid-RUN: rst=1 during RUN -> next cycle gnt=0, busy=0, no done; after release, req=1000 gives gnt=1000.
REQ-035 Max length: WIDTH=5, len=31 -> exactly 32 RUN cycles, done when cnt_count=31; the length input is not re-sampled after the grant, so changing len during RUN has no effect.
